// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIF FFT address sequencer.
//   FFT_LOG2N / FFT_N / FFT_TW : default transform size and twiddle address width
//   state_t                    : sequencer FSM states
//   span_of / twd_of           : butterfly span and twiddle index for a stage
package fft_pkg;
   localparam int FFT_LOG2N = 5;
   localparam int FFT_N     = 1 << FFT_LOG2N;
   localparam int FFT_TW    = FFT_LOG2N - 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // Distance between the two inputs of a butterfly in stage s.
   function automatic int span_of(input int log2n, input int s);
      return (1 << log2n) >> (s + 1);
   endfunction

   // Twiddle exponent for in-group position j of stage s.
   function automatic int twd_of(input int j, input int s);
      return j << s;
   endfunction
endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register that turns issued read addresses/enables into
// the matching write-back addresses/enables.
//   clk, rst : clock, synchronous active-high clear (drops pending writes)
//   din      : {rd_en, lane_b, rd_addr3..0} issued this cycle
//   dout     : din from exactly DEPTH cycles earlier (DEPTH >= 1)
module fft_addr_delay #(
   parameter int DEPTH = 2,
   parameter int W     = 22
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   logic [DEPTH-1:0][W-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[DEPTH-1];
endmodule

// File: rtl/fft_pe_sched.sv
// Address/control sequencer for one dual-butterfly radix-2 DIF PE running an
// in-place N-point FFT over a 4R/4W sample RAM.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a transform (only honoured in IDLE)
//   busy, done        : run in progress / one-cycle completion pulse
//   stage             : current stage 0..LOG2N-1 (0 when not busy)
//   rd_en, rd_addr0-3 : read request topA, botA, topB, botB
//   twd_addr          : twiddle ROM address, valid with rd_en
//   wr_en_a/b, wr_addr0-3 : write-back, rd side delayed RD_LAT+PE_LAT cycles
module fft_pe_sched
   import fft_pkg::*;
#(
   parameter int LOG2N  = FFT_LOG2N,
   parameter int RD_LAT = 1,
   parameter int PE_LAT = 1,
   parameter int AW     = LOG2N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [2:0]       stage,
   output logic             rd_en,
   output logic [AW-1:0]    rd_addr0,
   output logic [AW-1:0]    rd_addr1,
   output logic [AW-1:0]    rd_addr2,
   output logic [AW-1:0]    rd_addr3,
   output logic [LOG2N-2:0] twd_addr,
   output logic             wr_en_a,
   output logic             wr_en_b,
   output logic [AW-1:0]    wr_addr0,
   output logic [AW-1:0]    wr_addr1,
   output logic [AW-1:0]    wr_addr2,
   output logic [AW-1:0]    wr_addr3
);
   localparam int N  = 1 << LOG2N;
   localparam int TW = LOG2N - 1;
   localparam int L  = RD_LAT + PE_LAT;
   localparam int KW = LOG2N - 1;               // op counter covers N/2 ops
   localparam int DW = (L > 1) ? $clog2(L) : 1;

   state_t         state_q, state_d;
   logic [2:0]     stage_q;
   logic [KW-1:0]  k_q;
   logic [DW-1:0]  drn_q;
   logic           last_op, last_stage, drn_end, lane_b;

   // Stage 0 runs one lane over N/2 ops; later stages run both lanes over N/4.
   assign last_op    = (stage_q == '0) ? (k_q == KW'(N/2 - 1)) : (k_q == KW'(N/4 - 1));
   assign last_stage = (stage_q == 3'(LOG2N - 1));
   assign drn_end    = (drn_q == DW'(L - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         stage_q <= '0;
         k_q     <= '0;
         drn_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               stage_q <= '0;
               k_q     <= '0;
               drn_q   <= '0;
            end
            RUN: k_q <= last_op ? '0 : k_q + 1'b1;
            DRAIN: begin
               if (drn_end) begin
                  drn_q <= '0;
                  if (!last_stage) stage_q <= stage_q + 1'b1;
               end else begin
                  drn_q <= drn_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_op) state_d = DRAIN;
         DRAIN:   if (drn_end) state_d = last_stage ? DONE : RUN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy  = (state_q == RUN) || (state_q == DRAIN);
   assign done  = (state_q == DONE);
   assign stage = busy ? stage_q : '0;
   assign rd_en = (state_q == RUN);
   assign lane_b = rd_en && (stage_q != '0);

   // Group p = k / span and position j = k mod span are shifts/masks since
   // span is a power of two. Stage 0 falls out of the same formula (p = 0).
   always_comb begin
      int span, j, p, top_a;
      span  = span_of(LOG2N, int'(stage_q));
      j     = int'(k_q) & (span - 1);
      p     = int'(k_q) >> (LOG2N - 1 - int'(stage_q));
      top_a = (p << (LOG2N + 1 - int'(stage_q))) + j;
      rd_addr0 = rd_en  ? AW'(top_a)            : '0;
      rd_addr1 = rd_en  ? AW'(top_a + span)     : '0;
      rd_addr2 = lane_b ? AW'(top_a + 2 * span) : '0;
      rd_addr3 = lane_b ? AW'(top_a + 3 * span) : '0;
      twd_addr = rd_en  ? TW'(twd_of(j, int'(stage_q))) : '0;
   end

   logic [4*AW+1:0] rd_bus, wr_bus;
   assign rd_bus = {rd_en, lane_b, rd_addr3, rd_addr2, rd_addr1, rd_addr0};

   fft_addr_delay #(.DEPTH(L), .W(4*AW+2)) u_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (rd_bus),
      .dout (wr_bus)
   );

   assign {wr_en_a, wr_en_b, wr_addr3, wr_addr2, wr_addr1, wr_addr0} = wr_bus;
endmodule

// File: tb/tb_fft_pe_sched.sv
module tb_fft_pe_sched;
   localparam int LOG2N = 5, N = 32, AW = 5, TW = 4, L = 2, S = 5;
   localparam int T_DONE = 59, T_END = 62;

   logic clk = 1'b0, rst, start;
   logic busy, done, rd_en, wr_en_a, wr_en_b;
   logic [2:0] stage;
   logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
   logic [AW-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
   logic [TW-1:0] twd_addr;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   fft_pe_sched #(.LOG2N(LOG2N), .RD_LAT(1), .PE_LAT(1), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
      .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_addr3(rd_addr3), .twd_addr(twd_addr), .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_addr3(wr_addr3)
   );

   typedef struct packed {
      logic busy, done, rd_en;
      logic [2:0] stage;
      logic [3:0][AW-1:0] ra;
      logic [TW-1:0] twd;
      logic wen_a, wen_b;
      logic [3:0][AW-1:0] wa;
   } snap_t;

   typedef struct { int t; snap_t e; } vec_t;

   snap_t exp_q [0:T_END];
   logic  lane_q[0:T_END];
   snap_t obs   [0:T_END];
   vec_t  vt[11];

   function automatic snap_t snap();
      snap_t v;
      v.busy = busy; v.done = done; v.rd_en = rd_en; v.stage = stage;
      v.ra[0] = rd_addr0; v.ra[1] = rd_addr1; v.ra[2] = rd_addr2; v.ra[3] = rd_addr3;
      v.twd = twd_addr; v.wen_a = wr_en_a; v.wen_b = wr_en_b;
      v.wa[0] = wr_addr0; v.wa[1] = wr_addr1; v.wa[2] = wr_addr2; v.wa[3] = wr_addr3;
      return v;
   endfunction

   function automatic snap_t mk(input int b, d, re, st, a0, a1, a2, a3, tw, wa_en, wb_en,
                                input int w0, w1, w2, w3);
      snap_t v;
      v.busy = b[0]; v.done = d[0]; v.rd_en = re[0]; v.stage = 3'(st);
      v.ra[0] = AW'(a0); v.ra[1] = AW'(a1); v.ra[2] = AW'(a2); v.ra[3] = AW'(a3);
      v.twd = TW'(tw); v.wen_a = wa_en[0]; v.wen_b = wb_en[0];
      v.wa[0] = AW'(w0); v.wa[1] = AW'(w1); v.wa[2] = AW'(w2); v.wa[3] = AW'(w3);
      return v;
   endfunction

   task automatic cmp(input string name, input int t, input snap_t got, input snap_t expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s t=%0d got=%h want=%h", name, t, got, expv);
      end
   endtask

   // Reference schedule: walk the butterfly groups of each stage in order,
   // then L idle drain cycles, then a done cycle; writes echo reads L later.
   task automatic build_model();
      int t;
      for (int i = 0; i <= T_END; i++) begin exp_q[i] = '0; lane_q[i] = 1'b0; end
      t = 1;
      for (int s = 0; s < S; s++) begin
         int span;
         span = N >> (s + 1);
         if (s == 0) begin
            for (int k = 0; k < N/2; k++) begin
               exp_q[t] = mk(1, 0, 1, 0, k, k + span, 0, 0, k, 0, 0, 0, 0, 0, 0);
               t++;
            end
         end else begin
            for (int g = 0; g < N; g += 4 * span)
               for (int j = 0; j < span; j++) begin
                  exp_q[t] = mk(1, 0, 1, s, g + j, g + j + span, g + j + 2*span,
                                g + j + 3*span, j << s, 0, 0, 0, 0, 0, 0);
                  lane_q[t] = 1'b1;
                  t++;
               end
         end
         for (int d = 0; d < L; d++) begin
            exp_q[t].busy = 1'b1; exp_q[t].stage = 3'(s); t++;
         end
      end
      exp_q[t].done = 1'b1;
      for (int i = L; i <= T_END; i++) begin
         exp_q[i].wen_a = exp_q[i-L].rd_en;
         exp_q[i].wen_b = lane_q[i-L];
         exp_q[i].wa    = lane_q[i-L] ? exp_q[i-L].ra : {{2*AW{1'b0}}, exp_q[i-L].ra[1], exp_q[i-L].ra[0]};
      end
   endtask

   // One transform from start; optional spurious start pulses; optional reset at abort_t.
   task automatic do_run(input bit spur, input int abort_t);
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(negedge clk); cmp("idle_gap", 0, snap(), '0); end
      start = 1'b1;
      for (int t = 1; t <= T_END; t++) begin
         @(negedge clk);
         obs[t] = snap();
         cmp("sched", t, obs[t], exp_q[t]);
         start = 1'b0;
         if (spur && t < T_DONE - 1 && (t == 5 || t == 17 || $urandom_range(0, 7) == 0))
            start = 1'b1;
         if (t == abort_t) begin
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            cmp("abort_zero", t, snap(), '0);
            repeat (4) begin @(negedge clk); cmp("abort_idle", t, snap(), '0); end
            return;
         end
      end
   endtask

   // Model RAM (read latency 1), twiddle ROM (latency 1) and registered PE.
   typedef struct { int re; int im; } cpx_t;
   cpx_t mem[N];
   cpx_t rq[4], po[4], rn[4];
   int tq_re = 16384, tq_im = 0;
   int tw_re[N/2], tw_im[N/2];

   function automatic void bfly(input cpx_t a, input cpx_t b, input int wr, input int wi,
                                output cpx_t s, output cpx_t d);
      int dr, di;
      s.re = a.re + b.re; s.im = a.im + b.im;
      dr = a.re - b.re; di = a.im - b.im;
      d.re = (dr * wr - di * wi + 8192) >>> 14;
      d.im = (dr * wi + di * wr + 8192) >>> 14;
   endfunction

   always @(negedge clk) begin
      rn[0] = mem[rd_addr0]; rn[1] = mem[rd_addr1];
      rn[2] = mem[rd_addr2]; rn[3] = mem[rd_addr3];
      if (wr_en_a) begin mem[wr_addr0] = po[0]; mem[wr_addr1] = po[2]; end
      if (wr_en_b) begin mem[wr_addr2] = po[1]; mem[wr_addr3] = po[3]; end
      bfly(rq[0], rq[1], tq_re, tq_im, po[0], po[2]);
      bfly(rq[2], rq[3], tq_re, tq_im, po[1], po[3]);
      rq = rn;
      tq_re = tw_re[twd_addr];
      tq_im = tw_im[twd_addr];
   end

   initial begin
      for (int i = 0; i < N/2; i++) begin
         tw_re[i] = int'( $cos(2.0 * 3.14159265358979 * real'(i) / real'(N)) * 16384.0);
         tw_im[i] = int'(-$sin(2.0 * 3.14159265358979 * real'(i) / real'(N)) * 16384.0);
      end
      for (int i = 0; i < N; i++) begin mem[i].re = 0; mem[i].im = 0; end
      for (int i = 0; i < 4; i++) begin rq[i] = mem[0]; po[i] = mem[0]; rn[i] = mem[0]; end

      vt[0]  = '{1,  mk(1,0,1,0,  0,16, 0, 0,  0, 0,0,  0, 0, 0, 0)};
      vt[1]  = '{2,  mk(1,0,1,0,  1,17, 0, 0,  1, 0,0,  0, 0, 0, 0)};
      vt[2]  = '{3,  mk(1,0,1,0,  2,18, 0, 0,  2, 1,0,  0,16, 0, 0)};
      vt[3]  = '{17, mk(1,0,0,0,  0, 0, 0, 0,  0, 1,0, 14,30, 0, 0)};
      vt[4]  = '{18, mk(1,0,0,0,  0, 0, 0, 0,  0, 1,0, 15,31, 0, 0)};
      vt[5]  = '{19, mk(1,0,1,1,  0, 8,16,24,  0, 0,0,  0, 0, 0, 0)};
      vt[6]  = '{26, mk(1,0,1,1,  7,15,23,31, 14, 1,1,  5,13,21,29)};
      vt[7]  = '{52, mk(1,0,1,4, 12,13,14,15,  0, 1,1,  4, 5, 6, 7)};
      vt[8]  = '{58, mk(1,0,0,4,  0, 0, 0, 0,  0, 1,1, 28,29,30,31)};
      vt[9]  = '{59, mk(0,1,0,0,  0, 0, 0, 0,  0, 0,0,  0, 0, 0, 0)};
      vt[10] = '{60, mk(0,0,0,0,  0, 0, 0, 0,  0, 0,0,  0, 0, 0, 0)};

      build_model();
      rst = 1'b1; start = 1'b0;
      repeat (2) @(negedge clk);
      cmp("reset_state", 0, snap(), '0);
      rst = 1'b0;
      @(negedge clk);
      cmp("idle_after_reset", 0, snap(), '0);

      // Clean run, then directed vectors against the captured trace.
      do_run(1'b0, 0);
      foreach (vt[i]) cmp("vector", vt[i].t, obs[vt[i].t], vt[i].e);

      // Spurious starts in RUN and DRAIN must not disturb the sequence.
      do_run(1'b1, 0);

      // Reset mid-stage 2 (ops occupy t=29..36), then a full rerun.
      do_run(1'b1, int'($urandom_range(30, 36)));
      do_run(1'b0, 0);

      // Reset and start in the same cycle: reset wins, nothing starts.
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      cmp("rst_start_same", 0, snap(), '0);
      @(negedge clk);
      cmp("rst_start_idle", 0, snap(), '0);

      // Impulse through the model datapath: every bin should be 1.0 (Q14).
      for (int i = 0; i < N; i++) begin mem[i].re = 0; mem[i].im = 0; end
      mem[0].re = 16384;
      do_run(1'b0, 0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (mem[i].re < 16383 || mem[i].re > 16385 || mem[i].im < -1 || mem[i].im > 1) begin
            failures++;
            $display("FAIL impulse_bin %0d got=(%0d,%0d) want=(16384,0)", i, mem[i].re, mem[i].im);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
